// File: rtl/ecc_op_sequencer.sv
// ecc_op_sequencer: sequences encode/decode/full-channel ops between APB regs and ECC codec
// Optional per-phase watchdog enabled by defining ECC_SEQ_TIMEOUT_EN.
module ecc_op_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            ctrl,
  input  logic [1:0]            codeword_width,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] noise,
  output logic                  enc_start,
  output logic [DATA_WIDTH-1:0] enc_data,
  input  logic                  enc_done,
  input  logic [DATA_WIDTH-1:0] enc_result,
  output logic                  dec_start,
  output logic [DATA_WIDTH-1:0] dec_data,
  input  logic                  dec_done,
  input  logic [DATA_WIDTH-1:0] dec_result,
  input  logic [1:0]            dec_num_err,
  output logic [1:0]            width_sel,
  output logic                  busy,
  output logic                  operation_done,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            num_of_errors
);
  typedef enum logic [2:0] {IDLE, ENC_RUN, NOISE, DEC_RUN, DONE} state_t;
  function automatic logic [DATA_WIDTH-1:0] mask_of(input logic [1:0] w);
    return w == 2'd0 ? DATA_WIDTH'(8'hff) : w == 2'd1 ? DATA_WIDTH'(16'hffff) : '1;
  endfunction
  state_t                state_q, state_d;
  logic [1:0]            ctrl_q, ctrl_d, width_q, width_d, nerr_q, nerr_d;
  logic [DATA_WIDTH-1:0] noise_q, noise_d, cw_q, cw_d, enc_data_q, enc_data_d;
  logic [DATA_WIDTH-1:0] dec_data_q, dec_data_d, data_out_q, data_out_d;
  logic                  enc_start_q, enc_start_d, dec_start_q, dec_start_d;
  logic [DATA_WIDTH-1:0] in_mask, mask;
`ifdef ECC_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          expired;
  assign expired = cnt_q == CW'(TIMEOUT_CYCLES - 1);
`endif
  assign in_mask = mask_of(codeword_width);
  assign mask    = mask_of(width_q);
  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    width_d     = width_q;
    nerr_d      = nerr_q;
    noise_d     = noise_q;
    cw_d        = cw_q;
    enc_data_d  = enc_data_q;
    dec_data_d  = dec_data_q;
    data_out_d  = data_out_q;
    enc_start_d = 1'b0;
    dec_start_d = 1'b0;
`ifdef ECC_SEQ_TIMEOUT_EN
    cnt_d       = cnt_q + 1'b1;
`endif
    case (state_q)
      IDLE: if (start) begin
        ctrl_d  = ctrl;
        width_d = codeword_width;
        noise_d = noise;
`ifdef ECC_SEQ_TIMEOUT_EN
        cnt_d   = '0;
`endif
        if (ctrl == 2'b11 || codeword_width == 2'b11) begin
          state_d    = DONE;
          data_out_d = '0;
          nerr_d     = 2'd3;
        end else if (ctrl == 2'b01) begin
          state_d     = DEC_RUN;
          dec_data_d  = data_in & in_mask;
          dec_start_d = 1'b1;
        end else begin
          state_d     = ENC_RUN;
          enc_data_d  = data_in & in_mask;
          enc_start_d = 1'b1;
        end
      end
      ENC_RUN: if (enc_done) begin
        state_d    = ctrl_q == 2'b10 ? NOISE : DONE;
        cw_d       = enc_result & mask;
        data_out_d = ctrl_q == 2'b10 ? data_out_q : enc_result & mask;
        nerr_d     = ctrl_q == 2'b10 ? nerr_q : 2'd0;
      end
`ifdef ECC_SEQ_TIMEOUT_EN
      else if (expired) begin
        state_d    = DONE;
        data_out_d = '0;
        nerr_d     = 2'd3;
      end
`endif
      NOISE: begin
        state_d     = DEC_RUN;
        dec_data_d  = (cw_q ^ noise_q) & mask;
        dec_start_d = 1'b1;
`ifdef ECC_SEQ_TIMEOUT_EN
        cnt_d       = '0;
`endif
      end
      DEC_RUN: if (dec_done) begin
        state_d    = DONE;
        data_out_d = dec_result & mask;
        nerr_d     = dec_num_err;
      end
`ifdef ECC_SEQ_TIMEOUT_EN
      else if (expired) begin
        state_d    = DONE;
        data_out_d = '0;
        nerr_d     = 2'd3;
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ctrl_q      <= '0;
      width_q     <= '0;
      nerr_q      <= '0;
      noise_q     <= '0;
      cw_q        <= '0;
      enc_data_q  <= '0;
      dec_data_q  <= '0;
      data_out_q  <= '0;
      enc_start_q <= 1'b0;
      dec_start_q <= 1'b0;
`ifdef ECC_SEQ_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      width_q     <= width_d;
      nerr_q      <= nerr_d;
      noise_q     <= noise_d;
      cw_q        <= cw_d;
      enc_data_q  <= enc_data_d;
      dec_data_q  <= dec_data_d;
      data_out_q  <= data_out_d;
      enc_start_q <= enc_start_d;
      dec_start_q <= dec_start_d;
`ifdef ECC_SEQ_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end
  assign enc_start      = enc_start_q;
  assign enc_data       = enc_data_q;
  assign dec_start      = dec_start_q;
  assign dec_data       = dec_data_q;
  assign width_sel      = width_q;
  assign busy           = state_q != IDLE;
  assign operation_done = state_q == DONE;
  assign data_out       = data_out_q;
  assign num_of_errors  = nerr_q;
endmodule

// File: tb/tb_ecc_op_sequencer.sv
// tb_ecc_op_sequencer: directed + random ops against a codec stub and an op-level reference model
module tb_ecc_op_sequencer;
  logic        clk = 0, rst = 1, start = 0;
  logic [1:0]  ctrl = 0, codeword_width = 0, width_sel, num_of_errors, dec_num_err;
  logic [31:0] data_in = 0, noise = 0, enc_data, dec_data, enc_result, dec_result, data_out;
  logic        enc_start, dec_start, enc_done, dec_done, busy, operation_done;
  logic        stub_enc_done = 0, stub_dec_done = 0, inj_dec_done = 0, enc_hold = 0;
  int          enc_left = 0, dec_left = 0, enc_kicks = 0, dec_kicks = 0, done_cnt = 0;
  int          n_cmp = 0, n_err = 0;
  logic [31:0] last_dec_data = 0;
  assign enc_done = stub_enc_done;
  assign dec_done = stub_dec_done | inj_dec_done;
  always #5 clk = ~clk;
  ecc_op_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .ctrl(ctrl), .codeword_width(codeword_width),
    .data_in(data_in), .noise(noise), .enc_start(enc_start), .enc_data(enc_data),
    .enc_done(enc_done), .enc_result(enc_result), .dec_start(dec_start), .dec_data(dec_data),
    .dec_done(dec_done), .dec_result(dec_result), .dec_num_err(dec_num_err),
    .width_sel(width_sel), .busy(busy), .operation_done(operation_done),
    .data_out(data_out), .num_of_errors(num_of_errors)
  );
  function automatic logic [31:0] enc_fn(input logic [31:0] x);
    return (x << 1) ^ x ^ 32'h0000_0100;
  endfunction
  function automatic logic [31:0] dec_fn(input logic [31:0] x);
    return {x[0], x[31:1]} ^ 32'h5A5A_5A5A;
  endfunction
  function automatic logic [1:0] err_fn(input logic [31:0] x);
    return x[3:2] == 2'd3 ? 2'd2 : x[3:2];
  endfunction
  function automatic logic [31:0] mask_of(input logic [1:0] w);
    return w == 0 ? 32'hFF : w == 1 ? 32'hFFFF : 32'hFFFF_FFFF;
  endfunction
  // Codec stub: done pulses 3 cycles after the kick, result bus carries junk otherwise.
  always @(posedge clk) begin
    stub_enc_done <= 0;
    stub_dec_done <= 0;
    enc_result    <= $urandom;
    dec_result    <= $urandom;
    dec_num_err   <= 2'($urandom);
    if (rst) begin
      enc_left <= 0;
      dec_left <= 0;
    end else begin
      if (enc_start) enc_left <= 2;
      else if (enc_left > 0) begin
        enc_left <= enc_left - 1;
        if (enc_left == 1 && !enc_hold) begin
          stub_enc_done <= 1;
          enc_result    <= enc_fn(enc_data);
        end
      end
      if (dec_start) dec_left <= 2;
      else if (dec_left > 0) begin
        dec_left <= dec_left - 1;
        if (dec_left == 1) begin
          stub_dec_done <= 1;
          dec_result    <= dec_fn(dec_data);
          dec_num_err   <= err_fn(dec_data);
        end
      end
    end
  end
  always @(negedge clk) begin
    if (enc_start) enc_kicks++;
    if (dec_start) begin
      dec_kicks++;
      last_dec_data = dec_data;
    end
    if (operation_done) done_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input logic [1:0] c, input logic [1:0] w, input logic [31:0] din,
                        input logic [31:0] nz, input bit spam, input bit timeout);
    logic [31:0] m, exp_d, cw, r, exp_dd;
    logic [1:0]  exp_e;
    int          exp_lat, k, e0, d0, n0;
    bit          ill;
    m = mask_of(w);
    ill = c == 3 || w == 3;
    cw = enc_fn(din & m) & m;
    r = (cw ^ nz) & m;
    exp_dd = c == 2 ? r : din & m;
    exp_d = ill || timeout ? 0 : c == 0 ? cw : dec_fn(exp_dd) & m;
    exp_e = ill || timeout ? 3 : c == 0 ? 0 : err_fn(exp_dd);
    exp_lat = ill ? 1 : timeout ? 65 : c == 2 ? 10 : 5;
    e0 = enc_kicks; d0 = dec_kicks; n0 = done_cnt;
    @(negedge clk);
    ctrl = c; codeword_width = w; data_in = din; noise = nz; start = 1;
    @(negedge clk);
    k = 1;
    start = spam; ctrl = 2'($urandom); data_in = $urandom; noise = $urandom;
    chk("busy_kick", busy, 1);
    chk("width_sel", width_sel, w);
    chk("enc_start", enc_start, !ill && c != 1);
    chk("dec_start", dec_start, !ill && c == 1);
    if (!ill && c != 1) chk("enc_data", enc_data, din & m);
    if (!ill && c == 1) chk("dec_data", dec_data, din & m);
    while (!operation_done && k < 200) begin
      @(negedge clk);
      k++;
      if (spam) begin start = 1; ctrl = 0; codeword_width = 2'($urandom); end
    end
    chk("latency", k, exp_lat);
    chk("data_out", data_out, exp_d);
    chk("num_of_errors", num_of_errors, exp_e);
    chk("width_hold", width_sel, w);
    chk("enc_kicks", enc_kicks - e0, !ill && c != 1);
    chk("dec_kicks", dec_kicks - d0, !ill && c != 0 && !timeout);
    if (!ill && c == 2) chk("noisy_dec_data", last_dec_data, r);
    @(negedge clk);
    start = 0;
    chk("done_pulses", done_cnt - n0, 1);
    chk("busy_idle", busy, 0);
    chk("data_out_held", data_out, exp_d);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", operation_done, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_errs", num_of_errors, 0);
    chk("rst_width", width_sel, 0);
    chk("rst_kicks", {enc_start, dec_start}, 0);
    rst = 0;
    run_op(2'b00, 2'b00, 32'hA5, 32'h0, 0, 0);
    run_op(2'b10, 2'b01, 32'h1234_5678, 32'h0004, 0, 0);
    run_op(2'b01, 2'b11, 32'hDEAD_BEEF, 32'h0, 0, 0);
    run_op(2'b01, 2'b10, 32'hCAFE_F00D, 32'h0, 1, 0);
    for (int i = 0; i < 24; i++)
      run_op(2'($urandom), 2'($urandom), $urandom, 32'(1) << $urandom_range(31, 0), 0, 0);
    begin
      int n0;
      n0 = done_cnt;
      @(negedge clk);
      ctrl = 2'b10; codeword_width = 2'b10; data_in = $urandom; start = 1;
      @(negedge clk);
      start = 0;
      repeat (4) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("abort_busy", busy, 0);
      chk("abort_data_out", data_out, 0);
      chk("abort_errs", num_of_errors, 0);
      chk("abort_width", width_sel, 0);
      inj_dec_done = 1;
      @(negedge clk);
      inj_dec_done = 0;
      repeat (4) @(negedge clk);
      chk("abort_no_done", done_cnt - n0, 0);
      chk("abort_idle", busy, 0);
    end
    run_op(2'b00, 2'b10, 32'h0BAD_CAFE, 32'h0, 0, 0);
`ifdef ECC_SEQ_TIMEOUT_EN
    enc_hold = 1;
    run_op(2'b00, 2'b01, 32'h55AA, 32'h0, 0, 1);
    enc_hold = 0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
